// File: rtl/divide_sched.sv
// Programmable divide-by-N sequencer: emits a tick every N clocks and a phase-zero
// level y, for a configured number of ticks or free-running until stopped.
module divide_sched #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             y,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DIV_W-1:0] phase;
  logic [CNT_W-1:0] remain;

  logic             handshake;
  logic             phase_last;
  logic             final_tick;
  logic [DIV_W-1:0] cfg_div_eff;

  // A divisor of 0 behaves as 1.
  assign cfg_div_eff = (cfg_div == '0) ? DIV_W'(1) : cfg_div;

  assign cfg_ready = reset_n && ((state == IDLE) || (state == ARMED));
  assign handshake = cfg_valid && cfg_ready;

  // Compare phase+1 against div_q in one extra bit so nothing ever wraps below zero.
  assign phase_last = ({1'b0, phase} + 1'b1) == {1'b0, div_q};
  assign final_tick = phase_last && (cnt_q != '0) && (remain == CNT_W'(1));

  // Outputs decode registered state only; no input reaches them combinationally.
  assign busy = (state == RUN);
  assign tick = busy && phase_last;
  assign y    = busy && (phase == '0);
  assign done = (state == FINISH);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of all others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      div_q  <= '0;
      cnt_q  <= '0;
      phase  <= '0;
      remain <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            div_q <= cfg_div_eff;
            cnt_q <= cfg_count;
            state <= ARMED;
          end
        end

        ARMED: begin
          if (handshake) begin
            div_q <= cfg_div_eff;
            cnt_q <= cfg_count;
          end
          if (start) begin
            state  <= RUN;
            phase  <= '0;
            // A same-cycle write supplies the count for this run directly.
            remain <= handshake ? cfg_count : cnt_q;
          end
        end

        RUN: begin
          phase <= phase_last ? '0 : phase + 1'b1;
          if (phase_last && (cnt_q != '0) && (remain != '0)) begin
            remain <= remain - 1'b1;
          end
          // Completion outranks a simultaneous stop.
          if (final_tick) begin
            state <= FINISH;
          end else if (stop) begin
            state <= ARMED;
            phase <= '0;
          end
        end

        FINISH: begin
          state <= ARMED;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_sched.sv
// Directed bench for divide_sched: records per-cycle output traces of each run
// and compares them against hand-derived cycle masks.
module tb_divide_sched;

  localparam int DIV_W = 8;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_count;
  logic             start;
  logic             stop;
  logic             tick;
  logic             y;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  logic [63:0] tick_tr, y_tr, busy_tr, done_tr, ready_tr;

  divide_sched #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_count (cfg_count),
    .start     (start),
    .stop      (stop),
    .tick      (tick),
    .y         (y),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then stable for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [DIV_W-1:0] div, input logic [CNT_W-1:0] cnt);
    cfg_valid = 1'b1;
    cfg_div   = div;
    cfg_count = cnt;
    step();
    cfg_valid = 1'b0;
  endtask

  // Sample start at one edge; on return the DUT is in run cycle 0.
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Record n cycles starting at the current cycle; stop / cfg_valid are
  // asserted during the given cycle index (-1 for never).
  task automatic capture(input int n, input int stop_cyc, input int cfg_cyc);
    tick_tr = '0; y_tr = '0; busy_tr = '0; done_tr = '0; ready_tr = '0;
    for (int i = 0; i < n; i++) begin
      tick_tr[i]  = tick;
      y_tr[i]     = y;
      busy_tr[i]  = busy;
      done_tr[i]  = done;
      ready_tr[i] = cfg_ready;
      stop      = (i == stop_cyc);
      cfg_valid = (i == cfg_cyc);
      step();
    end
    stop      = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    cfg_valid = 1'b1;
    start     = 1'b1;
    stop      = 1'b0;
    cfg_div   = 8'd3;
    cfg_count = 16'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({tick, y, busy, done, cfg_ready} !== 5'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: got %b want 00000", i, {tick, y, busy, done, cfg_ready});
      end
    end
    cfg_valid = 1'b0;
    reset_n   = 1'b1;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", cfg_ready);
    end
    // Still IDLE with no config, so start must not launch a run.
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    checks++;
    if ({busy, tick, cfg_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_no_config busy/tick/ready: got %b want 001", {busy, tick, cfg_ready});
    end
  endtask

  task automatic test_counted();
    write_cfg(8'd3, 16'd4);
    do_start();
    capture(14, -1, -1);
    checks++;
    if (tick_tr[13:0] !== 14'h0924) begin errors++; $display("FAIL counted_tick: got %h want 0924", tick_tr[13:0]); end
    checks++;
    if (y_tr[13:0] !== 14'h0249) begin errors++; $display("FAIL counted_y: got %h want 0249", y_tr[13:0]); end
    checks++;
    if (busy_tr[13:0] !== 14'h0FFF) begin errors++; $display("FAIL counted_busy: got %h want 0fff", busy_tr[13:0]); end
    checks++;
    if (done_tr[13:0] !== 14'h1000) begin errors++; $display("FAIL counted_done: got %h want 1000", done_tr[13:0]); end
    checks++;
    if (ready_tr[13:0] !== 14'h2000) begin errors++; $display("FAIL counted_ready: got %h want 2000", ready_tr[13:0]); end
  endtask

  task automatic test_div_zero();
    write_cfg(8'd0, 16'd2);
    do_start();
    // The write attempted in cycle 0 carries a different config that must be refused.
    cfg_div   = 8'd7;
    cfg_count = 16'd9;
    capture(3, -1, 0);
    checks++;
    if (tick_tr[2:0] !== 3'b011) begin errors++; $display("FAIL div0_tick: got %b want 011", tick_tr[2:0]); end
    checks++;
    if (y_tr[2:0] !== 3'b011) begin errors++; $display("FAIL div0_y: got %b want 011", y_tr[2:0]); end
    checks++;
    if (done_tr[2:0] !== 3'b100) begin errors++; $display("FAIL div0_done: got %b want 100", done_tr[2:0]); end
    checks++;
    if (ready_tr[2:0] !== 3'b000) begin errors++; $display("FAIL div0_ready_in_run: got %b want 000", ready_tr[2:0]); end
    step();
    do_start();
    capture(4, -1, -1);
    checks++;
    if (tick_tr[3:0] !== 4'b0011) begin errors++; $display("FAIL div0_cfg_kept_tick: got %b want 0011", tick_tr[3:0]); end
    checks++;
    if (done_tr[3:0] !== 4'b0100) begin errors++; $display("FAIL div0_cfg_kept_done: got %b want 0100", done_tr[3:0]); end
  endtask

  task automatic test_free_run_stop();
    write_cfg(8'd5, 16'd0);
    do_start();
    capture(12, 7, -1);
    checks++;
    if (tick_tr[11:0] !== 12'h010) begin errors++; $display("FAIL free_tick: got %h want 010", tick_tr[11:0]); end
    checks++;
    if (y_tr[11:0] !== 12'h021) begin errors++; $display("FAIL free_y: got %h want 021", y_tr[11:0]); end
    checks++;
    if (busy_tr[11:0] !== 12'h0FF) begin errors++; $display("FAIL free_busy: got %h want 0ff", busy_tr[11:0]); end
    checks++;
    if (done_tr[11:0] !== 12'h000) begin errors++; $display("FAIL free_done: got %h want 000", done_tr[11:0]); end
    checks++;
    if (ready_tr[11:0] !== 12'hF00) begin errors++; $display("FAIL free_armed_ready: got %h want f00", ready_tr[11:0]); end
    do_start();
    capture(7, 5, -1);
    checks++;
    if (tick_tr[6:0] !== 7'h10) begin errors++; $display("FAIL restart_tick: got %h want 10", tick_tr[6:0]); end
    checks++;
    if (busy_tr[6:0] !== 7'h3F) begin errors++; $display("FAIL restart_busy: got %h want 3f", busy_tr[6:0]); end
    checks++;
    if (ready_tr[6:0] !== 7'h40) begin errors++; $display("FAIL restart_ready: got %h want 40", ready_tr[6:0]); end
  endtask

  task automatic test_stop_on_final();
    write_cfg(8'd2, 16'd3);
    do_start();
    capture(9, 5, -1);
    checks++;
    if (tick_tr[8:0] !== 9'h02A) begin errors++; $display("FAIL stopfinal_tick: got %h want 02a", tick_tr[8:0]); end
    checks++;
    if (y_tr[8:0] !== 9'h015) begin errors++; $display("FAIL stopfinal_y: got %h want 015", y_tr[8:0]); end
    checks++;
    if (done_tr[8:0] !== 9'h040) begin errors++; $display("FAIL stopfinal_done: got %h want 040", done_tr[8:0]); end
    checks++;
    if (ready_tr[8:0] !== 9'h180) begin errors++; $display("FAIL stopfinal_ready: got %h want 180", ready_tr[8:0]); end
  endtask

  task automatic test_reset_mid_run();
    write_cfg(8'd4, 16'd0);
    do_start();
    capture(3, -1, -1);
    reset_n = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_forced: got %b want 0", cfg_ready); end
    step();
    checks++;
    if ({tick, y, busy, done, cfg_ready} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got %b want 00000", {tick, y, busy, done, cfg_ready});
    end
    reset_n = 1'b1;
    start   = 1'b1;
    step();
    step();
    start = 1'b0;
    checks++;
    if ({busy, cfg_ready} !== 2'b01) begin errors++; $display("FAIL midrst_start_ignored busy/ready: got %b want 01", {busy, cfg_ready}); end
    write_cfg(8'd4, 16'd5);
    // Same-cycle write and start: the run must use N=2, count 2.
    cfg_valid = 1'b1;
    cfg_div   = 8'd2;
    cfg_count = 16'd2;
    do_start();
    cfg_valid = 1'b0;
    capture(6, -1, -1);
    checks++;
    if (tick_tr[5:0] !== 6'h0A) begin errors++; $display("FAIL bypass_tick: got %h want 0a", tick_tr[5:0]); end
    checks++;
    if (y_tr[5:0] !== 6'h05) begin errors++; $display("FAIL bypass_y: got %h want 05", y_tr[5:0]); end
    checks++;
    if (done_tr[5:0] !== 6'h10) begin errors++; $display("FAIL bypass_done: got %h want 10", done_tr[5:0]); end
    checks++;
    if (busy_tr[5:0] !== 6'h0F) begin errors++; $display("FAIL bypass_busy: got %h want 0f", busy_tr[5:0]); end
    checks++;
    if (ready_tr[5:0] !== 6'h20) begin errors++; $display("FAIL bypass_ready: got %h want 20", ready_tr[5:0]); end
  endtask

  initial begin
    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_count = '0;
    start     = 1'b0;
    stop      = 1'b0;
    test_reset();
    test_counted();
    test_div_zero();
    test_free_run_stop();
    test_stop_on_final();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divide_sched.md
# divide_sched

Programmable divide-by-N sequencer: schedules a phase counter that emits a one-cycle `tick` every N clocks and a phase-zero level `y`, for a configured number of ticks or free-running. Sits in front of the clock-enable consumers in the pipeline and replaces fixed divide-by-3 sequencing. Configuration is written over a valid/ready port; `start` and `stop` control runs, and `done` reports completion.

## Interface
- `DIV_W`, default 8: width of divisor N.
- `CNT_W`, default 16: width of the tick-count register.

- `clk` in 1: sole clock; all state changes on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `cfg_valid` in 1: configuration write request.
- `cfg_ready` out 1: configuration can be accepted this cycle.
- `cfg_div` in DIV_W: divisor N; 0 is treated as 1.
- `cfg_count` in CNT_W: ticks per run; 0 means free-run.
- `start` in 1: begin a run, level-sampled.
- `stop` in 1: abort a run, level-sampled.
- `tick` out 1: one-cycle strobe at phase N-1.
- `y` out 1: high while RUN and phase == 0.
- `busy` out 1: high while state is RUN.
- `done` out 1: one-cycle pulse after the final tick of a counted run.

## Operation
- States:
  - IDLE: no valid configuration.
  - ARMED: configuration held.
  - RUN: counting.
  - FINISH: one cycle.
- Internal registers:
  - `div_q`: effective N, computed as max(cfg_div, 1).
  - `cnt_q`: configured count.
  - `phase`: 0..N-1.
  - `remain`: CNT_W bits.
- `cfg_ready` = reset_n && (state == IDLE || state == ARMED). A handshake occurs when cfg_valid && cfg_ready.
- IDLE:
  - On a handshake, latch `div_q` and `cnt_q`, then go to ARMED.
  - `start` is ignored.
- ARMED:
  - A handshake overwrites the configuration and the state stays ARMED.
  - On `start`, go to RUN with phase = 0 and remain = cnt_q.
  - If a handshake and `start` occur in the same cycle, the new configuration is latched and the run uses it. `phase` and `remain` are loaded from the bypassed inputs.
- RUN:
  - `phase` increments each cycle and wraps from div_q-1 to 0.
  - tick = (phase == div_q-1); y = (phase == 0).
  - Each tick with cnt_q != 0 decrements `remain`.
  - A tick with remain == 1 transitions to FINISH.
  - `stop` transitions to ARMED with no `done`. The config is retained and `phase` is cleared.
  - If `stop` and the final tick occur in the same cycle, the tick is emitted and completion wins: go to FINISH.
  - `start` and cfg writes are ignored; `cfg_ready` = 0.
  - With cnt_q == 0 the run is free: `remain` is untouched and only `stop` exits.
- FINISH:
  - done = 1 and tick = 0 for one cycle, then go to ARMED.
  - `cfg_ready` = 0; `start` is ignored this cycle.
- When N = 1, `tick` and `y` are both high every RUN cycle.
- `phase` compare and `remain` arithmetic are unsigned and never underflow; `remain` is only decremented when nonzero.

## Timing
- Reset (reset_n low at a clock edge): next state IDLE; `div_q`, `cnt_q`, `phase`, `remain` = 0.
- Reset values of outputs: `tick`, `y`, `busy`, `done`, `cfg_ready` = 0.
- `cfg_ready` is forced to 0 while reset_n is low.
- Reset mid-run aborts immediately with no `done`, and the configuration is lost.
- Output timing: `tick`, `y`, `busy` and `done` are decoded from registered state with zero combinational input paths. `cfg_ready` depends only on state and `reset_n`.
- Cycle numbering: cycle 0 is the first cycle with state == RUN, which follows the edge that samples `start` in ARMED.
- Within a run:
  - y is high in cycles 0, N, 2N, ...
  - tick is high in cycles N-1, 2N-1, ...
  - For count C, the last tick is in cycle C·N-1.
  - `done` is in cycle C·N and `busy` is high for cycles 0..C·N-1.
  - ARMED resumes at cycle C·N+1, and the earliest restart produces RUN at cycle C·N+2.
- `stop` sampled in cycle k: state is ARMED in cycle k+1. A tick in cycle k is still emitted.

## Test plan
- Reset behaviour: hold reset_n low 3 cycles with cfg_valid = 1 and start = 1. Required: all outputs 0 during reset; after release, state IDLE and cfg_ready = 1; no config latched.
- Counted run: cfg_div = 3, cfg_count = 4, then start. Required:
  - ticks in cycles 2, 5, 8, 11;
  - y in cycles 0, 3, 6, 9;
  - done in cycle 12; busy in cycles 0–11;
  - cfg_ready = 1 again in cycle 13.
- Divisor 0, plus write during run: cfg_div = 0, cfg_count = 2, start. Required: ticks and y in cycles 0 and 1, done in cycle 2. Pulse cfg_valid in cycle 0: cfg_ready = 0 and the config is unchanged.
- Free-run with stop: cfg_div = 5, cfg_count = 0, start; assert stop in cycle 7. Required: tick in cycle 4 only, ARMED in cycle 8, done never asserted. Restarting yields a tick 4 cycles into the new run.
- Stop on final tick: cfg_div = 2, cfg_count = 3, stop in cycle 5. Required: tick in cycle 5, done in cycle 6.
- Reset mid-run, plus same-cycle config and start: reset_n low in cycle 3 of a div = 4 run gives all outputs 0 next cycle, and start is ignored until a new config is written. In ARMED, cfg_valid (div = 2) together with start: ticks in cycles 1, 3, ... using N = 2.
